// File: rtl/fadd_norm_if.sv
// Handshake and data bundle between the mantissa add stage, the normaliser and the round/pack stage.
// The master side is the upstream/downstream environment; the normaliser uses the slave side.
interface fadd_norm_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [5:1]  in_exp;
   logic [12:1] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [5:1]  out_exp;
   logic [11:1] out_mant;
   logic        out_zero;
   logic        out_uflow;
   logic        out_oflow;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant,
             out_zero, out_uflow, out_oflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant,
             out_zero, out_uflow, out_oflow
   );
endinterface

// File: rtl/fadd_norm_sequencer.sv
// Multi-cycle normaliser for the half-precision adder: shifts the raw sum left by up to
// STEP_MAX places per cycle (or right once on carry) until the hidden bit is set or e hits 1.
module fadd_norm_sequencer #(
   parameter int STEP_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   fadd_norm_if.slave  bus,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic [11:1] m;
   logic [5:1]  e;
   logic        sign_q;
   logic        zero_q;
   logic        uflow_q;
   logic        oflow_q;
   logic        valid_q;

   logic        accept;
   logic [3:0]  lzc;
   logic [4:0]  step;
   logic [11:1] m_shift;
   logic [5:1]  e_next;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready reaches DONE combinationally through out_ready so a finished result and the next
   // operand can swap on one edge; out_valid only falls after an edge with out_ready high.
   assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_valid = valid_q;
   assign bus.out_sign  = sign_q;
   assign bus.out_exp   = e;
   assign bus.out_mant  = m;
   assign bus.out_zero  = zero_q;
   assign bus.out_uflow = uflow_q;
   assign bus.out_oflow = oflow_q;
   assign dbg_state     = state;

   // In SHIFT m is non-zero with m[11] clear, so lzc is always 1..10.
   always_comb begin
      lzc = 4'd0;
      for (int i = 1; i <= 11; i++) begin
         if (m[i]) lzc = 4'(11 - i);
      end
      step = {1'b0, lzc};
      if (5'(STEP_MAX) < step) step = 5'(STEP_MAX);
      if ((e - 5'd1) < step) step = e - 5'd1;
      m_shift = m << step;
      e_next  = e - step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m       <= '0;
         e       <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
         oflow_q <= 1'b0;
         valid_q <= 1'b0;
      end else if (accept) begin
         sign_q  <= bus.in_sign;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
         oflow_q <= 1'b0;
         valid_q <= 1'b1;
         state   <= DONE;
         if (bus.in_exp == 5'd31) begin
            m <= bus.in_mant[11:1];
            e <= bus.in_exp;
         end else if (bus.in_mant[12]) begin
            // Carry: shift right once, dropping the lsb; an exponent of 31 means overflow.
            if (bus.in_exp == 5'd30) begin
               m       <= '0;
               e       <= 5'd31;
               oflow_q <= 1'b1;
            end else begin
               m <= bus.in_mant[12:2];
               e <= bus.in_exp + 5'd1;
            end
         end else if (bus.in_mant == 12'd0) begin
            m      <= '0;
            e      <= '0;
            zero_q <= 1'b1;
         end else if (bus.in_mant[11] || bus.in_exp == 5'd0) begin
            m <= bus.in_mant[11:1];
            e <= bus.in_exp;
         end else begin
            m       <= bus.in_mant[11:1];
            e       <= bus.in_exp;
            valid_q <= 1'b0;
            state   <= SHIFT;
         end
      end else begin
         case (state)
            SHIFT: begin
               if (e == 5'd1) begin
                  e       <= '0;
                  uflow_q <= 1'b1;
                  valid_q <= 1'b1;
                  state   <= DONE;
               end else begin
                  m <= m_shift;
                  e <= e_next;
                  if (step == {1'b0, lzc}) begin
                     valid_q <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fadd_norm_sequencer.sv
// Directed bench for fadd_norm_sequencer: a table of hand-computed vectors plus sequences for
// backpressure, stall during a long shift, same-edge reload and reset in SHIFT.
module tb_fadd_norm_sequencer;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_fail;

   fadd_norm_if bus();

   fadd_norm_sequencer #(.STEP_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   typedef struct {
      logic        sign;
      logic [4:0]  exp_in;
      logic [11:0] mant_in;
      logic [4:0]  x_exp;
      logic [10:0] x_mant;
      logic [2:0]  x_flags;   // {zero, uflow, oflow}
      int          x_lat;
   } vec_t;

   vec_t vecs[15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [2:0] flags();
      return {bus.out_zero, bus.out_uflow, bus.out_oflow};
   endfunction

   task automatic drive(input logic s, input logic [4:0] ex, input logic [11:0] mt);
      bus.in_sign  = s;
      bus.in_exp   = ex;
      bus.in_mant  = mt;
      bus.in_valid = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      bit seen;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      drive(v.sign, v.exp_in, v.mant_in);
      bus.out_ready = 1'b1;
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         lat++;
      end
      check({tag, "_timeout"}, 32'(seen), 32'd1);
      check({tag, "_lat"}, 32'(lat), 32'(v.x_lat));
      check({tag, "_exp"}, 32'(bus.out_exp), 32'(v.x_exp));
      check({tag, "_mant"}, 32'(bus.out_mant), 32'(v.x_mant));
      check({tag, "_sign"}, 32'(bus.out_sign), 32'(v.sign));
      check({tag, "_flags"}, 32'(flags()), 32'(v.x_flags));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      //              sign  exp_in  mant_in  x_exp  x_mant   flags   lat
      vecs[0]  = '{1'b0, 5'd10, 12'hC00, 5'd11, 11'h600, 3'b000, 1};  // carry
      vecs[1]  = '{1'b1, 5'd30, 12'h800, 5'd31, 11'h000, 3'b001, 1};  // carry overflow
      vecs[2]  = '{1'b0, 5'd20, 12'h001, 5'd10, 11'h400, 3'b000, 4};  // long shift
      vecs[3]  = '{1'b1, 5'd3,  12'h010, 5'd0,  11'h040, 3'b010, 3};  // underflow
      vecs[4]  = '{1'b0, 5'd12, 12'h000, 5'd0,  11'h000, 3'b100, 1};  // zero
      vecs[5]  = '{1'b1, 5'd31, 12'h955, 5'd31, 11'h155, 3'b000, 1};  // inf/NaN beats carry
      vecs[6]  = '{1'b0, 5'd15, 12'h4AB, 5'd15, 11'h4AB, 3'b000, 1};  // already normal
      vecs[7]  = '{1'b1, 5'd0,  12'h023, 5'd0,  11'h023, 3'b000, 1};  // denormal untouched
      vecs[8]  = '{1'b0, 5'd15, 12'h2AB, 5'd14, 11'h556, 3'b000, 2};  // shift by 1
      vecs[9]  = '{1'b1, 5'd20, 12'h040, 5'd16, 11'h400, 3'b000, 2};  // shift exactly STEP_MAX
      vecs[10] = '{1'b0, 5'd20, 12'h020, 5'd15, 11'h400, 3'b000, 3};  // STEP_MAX+1
      vecs[11] = '{1'b0, 5'd11, 12'h001, 5'd1,  11'h400, 3'b000, 4};  // lands exactly on e=1
      vecs[12] = '{1'b1, 5'd1,  12'h200, 5'd0,  11'h200, 3'b010, 2};  // e=1 at entry
      vecs[13] = '{1'b0, 5'd0,  12'hFFF, 5'd1,  11'h7FF, 3'b000, 1};  // carry from exp 0
      vecs[14] = '{1'b0, 5'd2,  12'h100, 5'd0,  11'h200, 3'b010, 3};  // exponent-limited step

      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_data", {bus.out_sign, bus.out_exp, bus.out_mant, flags()}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Backpressure: overflow result held 5 cycles, then swapped for a new operand on one edge.
      @(negedge clk);
      drive(1'b1, 5'd30, 12'h800);
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_flags", 32'(flags()), 32'b001);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold", {bus.out_valid, bus.in_ready, bus.out_sign, bus.out_exp, bus.out_mant,
                           flags()}, {1'b1, 1'b0, 1'b1, 5'd31, 11'h000, 3'b001});
      end
      drive(1'b0, 5'd10, 12'hC00);
      bus.out_ready = 1'b1;
      #1 check("bp_ready_comb", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 begin
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_data", {bus.out_sign, bus.out_exp, bus.out_mant}, {1'b0, 5'd11, 11'h600});
      check("b2b_flags_clear", 32'(flags()), 32'd0);
      bus.out_ready = 1'b1;

      // Long shift stalls upstream; the waiting operand is taken on the edge that drains DONE.
      @(negedge clk);
      drive(1'b0, 5'd20, 12'h001);
      @(posedge clk);
      #1 drive(1'b1, 5'd12, 12'h000);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("stall_ready_k%0d", c), 32'(bus.in_ready), 32'd0);
         check($sformatf("stall_valid_k%0d", c), 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      check("stall_done", {bus.out_valid, bus.in_ready, bus.out_exp, bus.out_mant},
            {1'b1, 1'b1, 5'd10, 11'h400});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("stall_next", {bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant, flags()},
            {1'b1, 1'b1, 5'd0, 11'h000, 3'b100});

      // Reset in SHIFT aborts the operation immediately.
      @(negedge clk);
      drive(1'b1, 5'd20, 12'h001);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("rs_in_shift", 32'(dbg_state), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rs_out_valid", 32'(bus.out_valid), 32'd0);
      check("rs_in_ready", 32'(bus.in_ready), 32'd1);
      check("rs_data", {bus.out_sign, bus.out_exp, bus.out_mant, flags()}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(99, vecs[8]);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
